// File: rtl/tdm_mux_8to1.sv
// Time-division 8:1 multiplexer. A frame of eight parallel channel words and an
// enable mask is captured on start. The enabled channels are then sent one per
// valid/ready transfer, in ascending channel order, with the channel index on
// dout_sel.
module tdm_mux_8to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8*WIDTH-1:0] din,
  input  logic [7:0]         ch_en,
  input  logic               dout_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [2:0]         dout_sel,
  output logic               dout_valid,
  output logic               dout_first,
  output logic               dout_last,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [8*WIDTH-1:0] shadow_q, shadow_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         sel_q, sel_d;
  logic               frame_done_q, frame_done_d;

  logic               xfer;
  logic               is_first;
  logic               is_last;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Index of the highest set bit (0 when the mask is empty).
  function automatic logic [2:0] highest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Next set bit strictly above s; returns s if there is none, so no wrap.
  function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] s);
    logic [2:0] r;
    r = s;
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k > int'(s))) r = 3'(k);
    end
    return r;
  endfunction

  assign is_first = (sel_q == lowest_bit(mask_q));
  assign is_last  = (sel_q == highest_bit(mask_q));
  assign xfer     = (state_q == StSend) && dout_ready;

  // Next-state: capture on start, advance on transfer, chain frames back to back.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (ch_en != 8'h00)) begin
          shadow_d = din;
          mask_d   = ch_en;
          sel_d    = lowest_bit(ch_en);
          state_d  = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (is_last) begin
            frame_done_d = 1'b1;
            if (start && (ch_en != 8'h00)) begin
              shadow_d = din;
              mask_d   = ch_en;
              sel_d    = lowest_bit(ch_en);
            end else begin
              state_d = StIdle;
            end
          end else begin
            sel_d = next_above(mask_q, sel_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      mask_q       <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs come only from registers; word fields are zeroed while idle.
  always_comb begin
    dout_valid = (state_q == StSend);
    busy       = (state_q == StSend);
    dout_sel   = sel_q;
    frame_done = frame_done_q;
    dout       = '0;
    dout_first = 1'b0;
    dout_last  = 1'b0;
    if (state_q == StSend) begin
      dout       = shadow_q[int'(sel_q)*WIDTH +: WIDTH];
      dout_first = is_first;
      dout_last  = is_last;
    end
  end

endmodule
